dsram_arbiter: RTL and testbench
================================

# dsram_arbiter

Single-port data SRAM arbiter with a posted store buffer. It sits between the ID-stage load requester and the MEM-stage store requester and owns the `data_sram_*` port. Loads have priority. Stores are posted into a FIFO and drained into SRAM on idle cycles. Full-word store-to-load forwarding removes most same-port conflict stalls.

## Interface
- `SB_DEPTH`, 4: store buffer entries; power of two, ≥2
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-high
- `ld_req` in 1: load request from ID
- `ld_addr` in 32: load byte address; word-aligned use of `[31:2]`
- `ld_gnt` out 1: load accepted this cycle (combinational)
- `ld_rvalid` out 1: load data valid (registered)
- `ld_rdata` out 32: load data, valid when `ld_rvalid`
- `st_req` in 1: store request from MEM
- `st_we` in 4: byte enables; nonzero
- `st_addr` in 32: store byte address
- `st_wdata` in 32: store data, byte lanes already aligned
- `st_ack` out 1: store accepted into buffer (combinational)
- `sb_empty` out 1: buffer empty; used by the trap handler to drain before redirect
- `data_sram_en` out 1: SRAM enable
- `data_sram_we` out 4: SRAM byte write enables
- `data_sram_addr` out 32: SRAM address; `{word,2'b00}`
- `data_sram_wdata` out 32: SRAM write data
- `data_sram_rdata` in 32: SRAM read data, one cycle after the read

## Operation
- **Buffer.** Circular FIFO. Each entry is `{waddr[29:0], we[3:0], wdata[31:0]}`. Write pointer, read pointer and `count` (width `$clog2(SB_DEPTH)+1`) wrap modulo `SB_DEPTH`.
- **Store accept.** `st_ack = st_req && count != SB_DEPTH`. A store is never accepted when the buffer is full, even if the buffer drains in the same cycle.
- **Address match.** A load matches an entry when the word addresses are equal and the entry is valid. The store being accepted in the same cycle counts as the youngest entry.
- **Forward.** If the youngest match has `we == 4'hF`, its data is forwarded. Set `ld_gnt=1` and leave the SRAM port free for draining.
- **Partial hit.** If the youngest match has partial `we`, set `ld_gnt=0` until no partial-youngest match remains.
- **Refused store.** If `st_req && !st_ack`, set `ld_gnt=0`. The store is older than the load and its data is not yet visible.
- **Port priority, highest first:**
  - (1) Buffer full and a non-forwarded load pending: drain the head; the load waits.
  - (2) Load granted and not forwarded: `data_sram_en=1`, `we=0`, `addr=ld_addr`.
  - (3) Buffer non-empty: drain the head (`en=1`, `we=head.we`, `addr/wdata=head`) and pop at the clock edge.
  - (4) Otherwise the port is idle: `en=0`, `we=0`.
- **Simultaneous push and pop** when neither full nor empty: `count` is unchanged and both pointers advance.
- **Push and pop in the same cycle when count==1:** the popped entry is the old head. A same-cycle push is never drained that cycle.
- **Reset (including mid-operation).** Pointers and `count` clear to 0 and buffer contents are discarded. Outputs go to: `ld_rvalid=0`, `ld_rdata=0`, `sb_empty=1`, `ld_gnt=0`, `st_ack=0`, `data_sram_en=0`, `data_sram_we=0`.

## Timing
- `ld_gnt`, `st_ack` and all `data_sram_*` outputs are combinational from the current inputs and registered state. There is no comb path from `data_sram_rdata` to them.
- Load latency is exactly 1 cycle: `ld_rvalid` is asserted on the cycle after `ld_gnt`.
- `ld_rdata` source:
  - SRAM grant: `data_sram_rdata`, selected by a registered flag.
  - Forward: a data register loaded at the grant edge.
- A store becomes SRAM-visible at the edge ending its drain cycle. The minimum is 1 cycle after `st_ack` when the port is free.
- `sb_empty` is registered state (`count==0`). It does not reflect a same-cycle `st_ack`.
- Requesters hold `req` and its payload stable until gnt/ack.

## Structure
- Package `dsram_pkg`:
  - `sb_entry_t` struct
  - `WORD_LSB=2`
  - `FULL_WE=4'hF`
  - port-owner enum `{PORT_IDLE, PORT_LOAD, PORT_DRAIN}`
- Sub-module `store_buffer`:
  - holds the FIFO storage and pointers
  - parallel match logic returning `hit`, `youngest_full` and `youngest_data`
  - the arbiter top contains the priority select and the load-return registers

## Test plan
- **Load only, empty buffer.** `ld_req` at 0x100 with SRAM word 0xDEADBEEF. Expect `ld_gnt=1`, `en=1`, `we=0`, `addr=0x100`; next cycle `ld_rvalid=1` with data 0xDEADBEEF.
- **Store then drain.** Store 0x200/`we=F`/0x11223344 with no loads. Expect `st_ack` in the same cycle; next cycle `we=F`, `addr=0x200`; then `sb_empty=1`.
- **Forward.** Store 0x300/F/0xCAFEF00D and, in the same cycle, load 0x300. Expect `ld_gnt=1`; next cycle data 0xCAFEF00D with the SRAM port used only for the drain.
- **Partial hit.** Buffer holds 0x304/`we=0011`; load 0x304. Expect `ld_gnt=0` until that entry drains; grant the following cycle, returning merged SRAM data.
- **Full and starvation.** Fill 4 stores while `ld_req` is held high at an unrelated address. Expect a 5th `st_ack=0` and a drain to win the port; `st_ack` rises after the pop.
- **Reset mid-drain.** Assert `reset` with 3 entries buffered. Expect `count=0`, `sb_empty=1` and `data_sram_en=0` immediately, and no further writes.

Source files
------------

// File: rtl/dsram_pkg.sv
// Shared types and constants for the data SRAM arbiter and its store buffer.
package dsram_pkg;

  localparam int unsigned WORD_LSB = 2;
  localparam int unsigned WADDR_W  = 32 - WORD_LSB;
  localparam logic [3:0]  FULL_WE  = 4'hF;

  // One posted store: word address, byte enables, lane-aligned data.
  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [3:0]         we;
    logic [31:0]        wdata;
  } sb_entry_t;

  // Which requester owns the SRAM port in the current cycle.
  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_LOAD,
    PORT_DRAIN
  } port_owner_e;

  // Word address of a byte address.
  function automatic logic [WADDR_W-1:0] word_of(input logic [31:0] addr);
    return addr[31:WORD_LSB];
  endfunction

endpackage

// File: rtl/store_buffer.sv
// Circular FIFO of posted stores with parallel youngest-match lookup for loads.
module store_buffer
  import dsram_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_push,
  input  sb_entry_t          i_push_entry,
  input  logic               i_pop,
  input  logic [WADDR_W-1:0] i_ld_word,
  output sb_entry_t          o_head,
  output logic               o_full,
  output logic               o_has_data,
  output logic               o_empty,
  output logic               o_hit,
  output logic               o_youngest_full,
  output logic [31:0]        o_youngest_data
);

  localparam int unsigned PW = $clog2(SB_DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_entry_t     r_mem [SB_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;
  logic [PW-1:0] w_idx;

  assign o_full     = (r_count == CW'(SB_DEPTH));
  assign o_has_data = (r_count != '0);
  assign o_empty    = r_empty;
  assign o_head     = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && o_has_data;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Entry storage; contents are don't-care outside the valid window.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  // Pointers, occupancy and registered empty flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Walk entries oldest to youngest so the last match wins; the incoming store is youngest.
  always_comb begin
    o_hit           = 1'b0;
    o_youngest_full = 1'b0;
    o_youngest_data = '0;
    w_idx           = r_rd_ptr;
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_idx = r_rd_ptr + PW'(i);
      if ((CW'(i) < r_count) && (r_mem[w_idx].waddr == i_ld_word)) begin
        o_hit           = 1'b1;
        o_youngest_full = (r_mem[w_idx].we == FULL_WE);
        o_youngest_data = r_mem[w_idx].wdata;
      end
    end
    if (w_push && (i_push_entry.waddr == i_ld_word)) begin
      o_hit           = 1'b1;
      o_youngest_full = (i_push_entry.we == FULL_WE);
      o_youngest_data = i_push_entry.wdata;
    end
  end

endmodule

// File: rtl/dsram_arbiter.sv
// Single-port data SRAM arbiter: loads first, stores posted and drained on idle cycles.
module dsram_arbiter
  import dsram_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_gnt,
  output logic        ld_rvalid,
  output logic [31:0] ld_rdata,
  input  logic        st_req,
  input  logic [3:0]  st_we,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  output logic        st_ack,
  output logic        sb_empty,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata
);

  sb_entry_t   w_push_entry;
  sb_entry_t   w_head;
  logic        w_full;
  logic        w_has_data;
  logic        w_empty;
  logic        w_hit;
  logic        w_yfull;
  logic [31:0] w_ydata;
  logic        w_st_ack;
  logic        w_refused;
  logic        w_fwd;
  logic        w_partial;
  logic        w_ld_gnt;
  port_owner_e w_owner;
  logic        w_pop;
  logic        w_unused;

  logic        r_ld_rvalid;
  logic        r_fwd_sel;
  logic [31:0] r_fwd_data;

  // Byte-offset bits are ignored; accesses are whole words.
  assign w_unused = ^{ld_addr[WORD_LSB-1:0], st_addr[WORD_LSB-1:0]};

  assign w_push_entry = '{waddr: word_of(st_addr), we: st_we, wdata: st_wdata};

  store_buffer #(
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk             (clk),
    .reset           (reset),
    .i_push          (w_st_ack),
    .i_push_entry    (w_push_entry),
    .i_pop           (w_pop),
    .i_ld_word       (word_of(ld_addr)),
    .o_head          (w_head),
    .o_full          (w_full),
    .o_has_data      (w_has_data),
    .o_empty         (w_empty),
    .o_hit           (w_hit),
    .o_youngest_full (w_yfull),
    .o_youngest_data (w_ydata)
  );

  // Accept/grant decisions; a refused store or partial youngest match holds the load off.
  assign w_st_ack  = st_req && !w_full && !reset;
  assign w_refused = st_req && w_full;
  assign w_fwd     = w_hit && w_yfull;
  assign w_partial = w_hit && !w_yfull;
  assign w_ld_gnt  = ld_req && !reset && !w_refused && !w_partial && (w_fwd || !w_full);

  assign ld_gnt   = w_ld_gnt;
  assign st_ack   = w_st_ack;
  assign sb_empty = w_empty;

  // Port owner priority: forced drain when full, then SRAM load, then opportunistic drain.
  always_comb begin
    w_owner = PORT_IDLE;
    if (reset) begin
      w_owner = PORT_IDLE;
    end else if (w_full && ld_req && !w_fwd) begin
      w_owner = PORT_DRAIN;
    end else if (w_ld_gnt && !w_fwd) begin
      w_owner = PORT_LOAD;
    end else if (w_has_data) begin
      w_owner = PORT_DRAIN;
    end
  end

  assign w_pop = (w_owner == PORT_DRAIN);

  // SRAM port drive for the selected owner.
  always_comb begin
    data_sram_en    = 1'b0;
    data_sram_we    = 4'h0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    case (w_owner)
      PORT_LOAD: begin
        data_sram_en   = 1'b1;
        data_sram_addr = {word_of(ld_addr), {WORD_LSB{1'b0}}};
      end
      PORT_DRAIN: begin
        data_sram_en    = 1'b1;
        data_sram_we    = w_head.we;
        data_sram_addr  = {w_head.waddr, {WORD_LSB{1'b0}}};
        data_sram_wdata = w_head.wdata;
      end
      default: begin
        data_sram_en = 1'b0;
      end
    endcase
  end

  // Load return: valid one cycle after grant, source chosen at the grant edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_rvalid <= 1'b0;
      r_fwd_sel   <= 1'b0;
      r_fwd_data  <= '0;
    end else begin
      r_ld_rvalid <= w_ld_gnt;
      r_fwd_sel   <= w_ld_gnt && w_fwd;
      if (w_ld_gnt && w_fwd) begin
        r_fwd_data <= w_ydata;
      end
    end
  end

  assign ld_rvalid = r_ld_rvalid;
  assign ld_rdata  = !r_ld_rvalid ? 32'h0 : (r_fwd_sel ? r_fwd_data : data_sram_rdata);

endmodule

// File: tb/tb_dsram_arbiter.sv
// Directed bench for dsram_arbiter with a behavioural single-port SRAM.
module tb_dsram_arbiter;

  logic        clk;
  logic        reset;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        st_req;
  logic [3:0]  st_we;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic        st_ack;
  logic        sb_empty;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  int total;
  int bad;
  int n_wr;
  int wr_snap;
  logic [31:0] mem [int];

  dsram_arbiter #(.SB_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .ld_req          (ld_req),
    .ld_addr         (ld_addr),
    .ld_gnt          (ld_gnt),
    .ld_rvalid       (ld_rvalid),
    .ld_rdata        (ld_rdata),
    .st_req          (st_req),
    .st_we           (st_we),
    .st_addr         (st_addr),
    .st_wdata        (st_wdata),
    .st_ack          (st_ack),
    .sb_empty        (sb_empty),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten words read as a pattern: 0x100 -> DEADBEEF, 0x304 -> DEADBCEB, 0x400 -> DEADBBEF.
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    int key;
    key = int'(a[31:2]);
    if (mem.exists(key)) return mem[key];
    return 32'hDEADBFEF ^ {16'h0, a[15:0]};
  endfunction

  // SRAM model: byte-masked writes, registered reads.
  always @(posedge clk) begin
    if (data_sram_en) begin
      if (data_sram_we != 4'h0) begin
        logic [31:0] w;
        w = rd_word(data_sram_addr);
        for (int b = 0; b < 4; b++) begin
          if (data_sram_we[b]) w[b*8 +: 8] = data_sram_wdata[b*8 +: 8];
        end
        mem[int'(data_sram_addr[31:2])] = w;
        n_wr = n_wr + 1;
      end else begin
        data_sram_rdata <= rd_word(data_sram_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st_drive(input logic r, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    st_req = r; st_we = we; st_addr = a; st_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0; bad = 0; n_wr = 0; wr_snap = 0;
    data_sram_rdata = 32'h0;
    reset = 1'b1;
    ld_req = 1'b1; ld_addr = 32'h100;
    st_drive(1'b1, 4'hF, 32'h100, 32'h55555555);
    #2;
    chk("rst_empty",   32'(sb_empty),     32'd1);
    chk("rst_rvalid",  32'(ld_rvalid),    32'd0);
    chk("rst_rdata",   ld_rdata,          32'h0);
    chk("rst_gnt",     32'(ld_gnt),       32'd0);
    chk("rst_ack",     32'(st_ack),       32'd0);
    chk("rst_en",      32'(data_sram_en), 32'd0);
    chk("rst_we",      32'(data_sram_we), 32'd0);
    step(); step();
    reset = 1'b0; ld_req = 1'b0; st_drive(1'b0, 4'h0, 32'h0, 32'h0);

    // Load only, empty buffer
    step(); ld_req = 1'b1; ld_addr = 32'h100; #1;
    chk("ld_gnt",  32'(ld_gnt),       32'd1);
    chk("ld_en",   32'(data_sram_en), 32'd1);
    chk("ld_we",   32'(data_sram_we), 32'd0);
    chk("ld_addr", data_sram_addr,    32'h100);
    step(); ld_req = 1'b0; #1;
    chk("ld_rvalid", 32'(ld_rvalid),  32'd1);
    chk("ld_rdata",  ld_rdata,        32'hDEADBEEF);
    chk("ld_idle",   32'(data_sram_en), 32'd0);

    // Store then drain
    step(); st_drive(1'b1, 4'hF, 32'h200, 32'h11223344); #1;
    chk("st_ack",      32'(st_ack),       32'd1);
    chk("st_empty_reg",32'(sb_empty),     32'd1);
    chk("st_no_drain", 32'(data_sram_en), 32'd0);
    step(); st_drive(1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("dr_empty", 32'(sb_empty),     32'd0);
    chk("dr_en",    32'(data_sram_en), 32'd1);
    chk("dr_we",    32'(data_sram_we), 32'hF);
    chk("dr_addr",  data_sram_addr,    32'h200);
    chk("dr_wdata", data_sram_wdata,   32'h11223344);
    step(); ld_req = 1'b1; ld_addr = 32'h200; #1;
    chk("dr_empty2", 32'(sb_empty), 32'd1);
    chk("rb_gnt",    32'(ld_gnt),   32'd1);
    step(); ld_req = 1'b0; #1;
    chk("rb_data", ld_rdata, 32'h11223344);

    // Forward from a same-cycle full-word store
    step(); st_drive(1'b1, 4'hF, 32'h300, 32'hCAFEF00D); ld_req = 1'b1; ld_addr = 32'h300; #1;
    chk("fw_ack", 32'(st_ack),       32'd1);
    chk("fw_gnt", 32'(ld_gnt),       32'd1);
    chk("fw_en",  32'(data_sram_en), 32'd0);
    step(); st_drive(1'b0, 4'h0, 32'h0, 32'h0); ld_req = 1'b0; #1;
    chk("fw_rvalid", 32'(ld_rvalid),    32'd1);
    chk("fw_rdata",  ld_rdata,          32'hCAFEF00D);
    chk("fw_dr_we",  32'(data_sram_we), 32'hF);
    chk("fw_dr_addr",data_sram_addr,    32'h300);

    // Partial hit stalls until the entry drains, then reads merged data
    step(); st_drive(1'b1, 4'h3, 32'h304, 32'hFFFF5566); ld_req = 1'b1; ld_addr = 32'h304; #1;
    chk("ph_ack",  32'(st_ack),       32'd1);
    chk("ph_gnt0", 32'(ld_gnt),       32'd0);
    chk("ph_en0",  32'(data_sram_en), 32'd0);
    step(); st_drive(1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("ph_gnt1",  32'(ld_gnt),       32'd0);
    chk("ph_dr_we", 32'(data_sram_we), 32'h3);
    chk("ph_dr_ad", data_sram_addr,    32'h304);
    step(); #1;
    chk("ph_gnt2", 32'(ld_gnt),       32'd1);
    chk("ph_ld_we",32'(data_sram_we), 32'd0);
    step(); ld_req = 1'b0; #1;
    chk("ph_data", ld_rdata, 32'hDEAD5566);

    // Full buffer with a load held at an unrelated address
    step(); ld_req = 1'b1; ld_addr = 32'h400; st_drive(1'b1, 4'hF, 32'h500, 32'hA0000000); #1;
    chk("fl0_ack",  32'(st_ack),    32'd1);
    chk("fl0_gnt",  32'(ld_gnt),    32'd1);
    chk("fl0_addr", data_sram_addr, 32'h400);
    step(); st_drive(1'b1, 4'hF, 32'h504, 32'hA0000001); #1;
    chk("fl1_ack",  32'(st_ack),    32'd1);
    chk("fl1_data", ld_rdata,       32'hDEADBBEF);
    step(); st_drive(1'b1, 4'hF, 32'h508, 32'hA0000002); #1;
    chk("fl2_ack",  32'(st_ack),    32'd1);
    step(); st_drive(1'b1, 4'hF, 32'h50C, 32'hA0000003); #1;
    chk("fl3_ack",  32'(st_ack),    32'd1);
    step(); st_drive(1'b1, 4'hF, 32'h510, 32'hA0000004); #1;
    chk("fl4_ack",   32'(st_ack),       32'd0);
    chk("fl4_gnt",   32'(ld_gnt),       32'd0);
    chk("fl4_we",    32'(data_sram_we), 32'hF);
    chk("fl4_addr",  data_sram_addr,    32'h500);
    chk("fl4_wdata", data_sram_wdata,   32'hA0000000);
    step(); #1;
    chk("fl5_ack",    32'(st_ack),       32'd1);
    chk("fl5_gnt",    32'(ld_gnt),       32'd1);
    chk("fl5_rvalid", 32'(ld_rvalid),    32'd0);
    chk("fl5_we",     32'(data_sram_we), 32'd0);
    step(); st_drive(1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("fl6_gnt",   32'(ld_gnt),     32'd0);
    chk("fl6_addr",  data_sram_addr,  32'h504);
    chk("fl6_wdata", data_sram_wdata, 32'hA0000001);

    // Reset while draining with three entries still buffered
    step(); ld_req = 1'b0; #1;
    chk("rd_en",   32'(data_sram_en), 32'd1);
    chk("rd_addr", data_sram_addr,    32'h508);
    chk("rd_nwr",  32'(n_wr),         32'd5);
    wr_snap = n_wr;
    reset = 1'b1; ld_req = 1'b1; ld_addr = 32'h508; st_drive(1'b1, 4'hF, 32'h600, 32'h1); #1;
    chk("rm_en",    32'(data_sram_en), 32'd0);
    chk("rm_empty", 32'(sb_empty),     32'd1);
    chk("rm_ack",   32'(st_ack),       32'd0);
    chk("rm_gnt",   32'(ld_gnt),       32'd0);
    step(); step();
    reset = 1'b0; ld_req = 1'b0; st_drive(1'b0, 4'h0, 32'h0, 32'h0);
    step(); step(); #1;
    chk("ra_en",    32'(data_sram_en), 32'd0);
    chk("ra_empty", 32'(sb_empty),     32'd1);
    chk("ra_nwr",   32'(n_wr),         32'(wr_snap));
    step(); ld_req = 1'b1; ld_addr = 32'h50C; #1;
    chk("ra_gnt", 32'(ld_gnt), 32'd1);
    step(); ld_addr = 32'h500; #1;
    chk("ra_50c", ld_rdata, 32'hDEADBAE3);
    step(); ld_req = 1'b0; #1;
    chk("ra_500", ld_rdata, 32'hA0000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
